// File: rtl/bp_be_dcache_trace_driver.sv
// Trace replay initiator for the dcache harness: issues packets from a ROM,
// scoreboards results in order and reports mismatch/unexpected/timeout status.
module bp_be_dcache_trace_driver #(
    parameter int dcache_pkt_width_p = 32,
    parameter int ptag_width_p = 28,
    parameter int dword_width_p = 64,
    parameter int trace_els_p = 256,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p = 4096,
    localparam int trace_addr_width_lp = $clog2(trace_els_p),
    localparam int trace_width_lp =
        2 + dword_width_p + ptag_width_p + dcache_pkt_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           start_i,
    output logic [trace_addr_width_lp-1:0] trace_addr_o,
    input  logic [trace_width_lp-1:0]      trace_data_i,
    output logic [dcache_pkt_width_p-1:0]  dcache_pkt_o,
    output logic [ptag_width_p-1:0]        ptag_o,
    output logic                           dcache_pkt_v_o,
    input  logic                           dcache_pkt_ready_i,
    input  logic                           v_i,
    input  logic [dword_width_p-1:0]       data_i,
    output logic                           done_o,
    output logic                           error_o,
    output logic                           timeout_o,
    output logic                           unexpected_o,
    output logic [15:0]                    mismatch_count_o,
    output logic [trace_addr_width_lp-1:0] first_err_idx_o
);

    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_w_lp =
        (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int tmr_w_lp = $clog2(timeout_p + 1);
    localparam int exp_lsb_lp = ptag_width_p + dcache_pkt_width_p;

    localparam logic [cnt_w_lp-1:0] max_out_lp =
        cnt_w_lp'(max_outstanding_p);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp =
        ptr_w_lp'(max_outstanding_p - 1);
    localparam logic [tmr_w_lp-1:0] tmr_last_lp =
        tmr_w_lp'(timeout_p - 1);
    localparam logic [trace_addr_width_lp-1:0] addr_last_lp =
        trace_addr_width_lp'(trace_els_p - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [trace_addr_width_lp-1:0] addr_q, addr_d;
    logic [cnt_w_lp-1:0]            cnt_q, cnt_d;
    logic [ptr_w_lp-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]            rd_ptr_q, rd_ptr_d;
    logic [tmr_w_lp-1:0]            tmr_q, tmr_d;
    logic                           timeout_q, timeout_d;
    logic                           unexp_q, unexp_d;
    logic [15:0]                    mcnt_q, mcnt_d;
    logic [trace_addr_width_lp-1:0] ferr_q, ferr_d;

    // Scoreboard storage needs no reset: occupancy is tracked by cnt_q.
    logic                           sb_check_q [max_outstanding_p];
    logic [dword_width_p-1:0]       sb_exp_q   [max_outstanding_p];
    logic [trace_addr_width_lp-1:0] sb_idx_q   [max_outstanding_p];

    logic                     entry_end;
    logic                     entry_check;
    logic [dword_width_p-1:0] entry_exp;

    logic busy;
    logic fire;
    logic pop;
    logic mismatch;
    logic timeout_hit;
    logic at_last;

    assign entry_end   = trace_data_i[trace_width_lp-1];
    assign entry_check = trace_data_i[trace_width_lp-2];
    assign entry_exp   = trace_data_i[exp_lsb_lp +: dword_width_p];

    assign ptag_o       = trace_data_i[dcache_pkt_width_p +: ptag_width_p];
    assign dcache_pkt_o = trace_data_i[0 +: dcache_pkt_width_p];

    assign busy = (state_q == RUN) || (state_q == DRAIN);

    assign dcache_pkt_v_o = (state_q == RUN) && !entry_end
                         && (cnt_q < max_out_lp);

    assign fire    = dcache_pkt_v_o && dcache_pkt_ready_i;
    assign pop     = v_i && busy && (cnt_q != '0);
    assign at_last = (addr_q == addr_last_lp);

    assign mismatch = pop && sb_check_q[rd_ptr_q]
                   && (data_i != sb_exp_q[rd_ptr_q]);

    assign timeout_hit = busy && !v_i && (cnt_q != '0)
                      && (tmr_q == tmr_last_lp);

    function automatic logic [ptr_w_lp-1:0] ptr_inc(
        input logic [ptr_w_lp-1:0] p
    );
        return (p == ptr_last_lp) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (!at_last) begin
                addr_d = addr_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({fire, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        tmr_d     = tmr_q + 1'b1;
        timeout_d = timeout_q || timeout_hit;
        unexp_d   = unexp_q || (v_i && !pop);
        mcnt_d    = mcnt_q;
        ferr_d    = ferr_q;
        if (!busy || v_i || (cnt_q == '0)) begin
            tmr_d = '0;
        end
        if (mismatch) begin
            if (mcnt_q == '0) begin
                ferr_d = sb_idx_q[rd_ptr_q];
            end
            if (mcnt_q != 16'hFFFF) begin
                mcnt_d = mcnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (timeout_hit) begin
                    state_d = DONE;
                end else if (entry_end || (fire && at_last)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (timeout_hit || (cnt_d == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
            unexp_q   <= 1'b0;
            mcnt_q    <= '0;
            ferr_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
            unexp_q   <= unexp_d;
            mcnt_q    <= mcnt_d;
            ferr_q    <= ferr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            sb_check_q[wr_ptr_q] <= entry_check;
            sb_exp_q[wr_ptr_q]   <= entry_exp;
            sb_idx_q[wr_ptr_q]   <= addr_q;
        end
    end

    assign trace_addr_o     = addr_q;
    assign done_o           = (state_q == DONE);
    assign timeout_o        = timeout_q;
    assign unexpected_o     = unexp_q;
    assign mismatch_count_o = mcnt_q;
    assign first_err_idx_o  = ferr_q;
    assign error_o          = timeout_q || unexp_q || (mcnt_q != '0);

endmodule

// File: tb/tb_bp_be_dcache_trace_driver.sv
// Directed bench for bp_be_dcache_trace_driver with a ROM model and a
// fixed-latency responder returning per-index data.
module tb_bp_be_dcache_trace_driver;

    localparam int PW = 16;
    localparam int TW = 12;
    localparam int DW = 64;
    localparam int EL = 32;
    localparam int MO = 8;
    localparam int TO = 64;
    localparam int AW = 5;
    localparam int WW = 2 + DW + TW + PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic          man_v = 1'b0;
    logic [DW-1:0] man_data = '0;
    logic          resp_v = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic          resp_en = 1'b0;

    logic [WW-1:0] rom [EL];
    logic [DW-1:0] resp_mem [EL];

    logic [AW-1:0] trace_addr;
    logic [WW-1:0] trace_data;
    logic [PW-1:0] pkt;
    logic [TW-1:0] ptag;
    logic          pkt_v;
    logic          v_in;
    logic [DW-1:0] data_in;
    logic          done;
    logic          error;
    logic          timeout;
    logic          unexpected;
    logic [15:0]   mcount;
    logic [AW-1:0] ferr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fire_cnt = 0;

    typedef struct {
        int due;
        int idx;
    } rsp_t;
    rsp_t rq[$];

    assign v_in       = man_v | resp_v;
    assign data_in    = man_v ? man_data : resp_data;
    assign trace_data = rom[trace_addr];

    bp_be_dcache_trace_driver #(
        .dcache_pkt_width_p(PW),
        .ptag_width_p(TW),
        .dword_width_p(DW),
        .trace_els_p(EL),
        .max_outstanding_p(MO),
        .timeout_p(TO)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .start_i(start),
        .trace_addr_o(trace_addr),
        .trace_data_i(trace_data),
        .dcache_pkt_o(pkt),
        .ptag_o(ptag),
        .dcache_pkt_v_o(pkt_v),
        .dcache_pkt_ready_i(ready),
        .v_i(v_in),
        .data_i(data_in),
        .done_o(done),
        .error_o(error),
        .timeout_o(timeout),
        .unexpected_o(unexpected),
        .mismatch_count_o(mcount),
        .first_err_idx_o(ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pkt_v && ready) begin
            fire_cnt <= fire_cnt + 1;
        end
    end

    // Result for a fire sampled at edge k is presented for edge k+3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq.delete();
        end else if (resp_en && pkt_v && ready) begin
            rq.push_back('{due: cyc + 3, idx: int'(trace_addr)});
        end
    end

    always @(negedge clk) begin
        resp_v = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            resp_v    = 1'b1;
            resp_data = resp_mem[rq[0].idx];
            void'(rq.pop_front());
        end
    end

    function automatic logic [WW-1:0] mk(
        input logic e, input logic c, input logic [DW-1:0] x,
        input logic [TW-1:0] t, input logic [PW-1:0] p
    );
        return {e, c, x, t, p};
    endfunction

    task automatic check(
        input string tag, input logic [63:0] obs, input logic [63:0] exp
    );
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < EL; i++) begin
            rom[i]      = mk(1'b1, 1'b0, '0, '0, '0);
            resp_mem[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        man_v   = 1'b0;
        resp_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int k = 0;
        while (!done && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic load_basic();
        clear_rom();
        rom[0] = mk(1'b0, 1'b1, 64'hA5A5_0000_0000_0001, 12'h100, 16'h1000);
        rom[1] = mk(1'b0, 1'b0, 64'h0, 12'h101, 16'h1001);
        rom[2] = mk(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 12'h102, 16'h1002);
        rom[3] = mk(1'b0, 1'b0, 64'h0, 12'h103, 16'h1003);
        resp_mem[0] = 64'hA5A5_0000_0000_0001;
        resp_mem[1] = 64'hFFFF_FFFF;
        resp_mem[2] = 64'h0123_4567_89AB_CDEF;
        resp_mem[3] = 64'h1234;
    endtask

    initial begin
        int nv;
        logic dprev;
        logic stable;
        int f0;
        logic [PW-1:0] p0;
        logic [TW-1:0] t0;
        int k;

        // T1: basic replay with correct data
        clear_rom();
        do_reset();
        check("rst_addr", 64'(trace_addr), 64'd0);
        check("rst_pkt_v", 64'(pkt_v), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        load_basic();
        ready   = 1'b1;
        resp_en = 1'b1;
        pulse_start();
        check("t1_first_v", 64'(pkt_v), 64'd1);
        check("t1_first_pkt", 64'(pkt), 64'h1000);
        nv    = 0;
        dprev = done;
        for (int i = 0; i < 60 && nv < 4; i++) begin
            @(posedge clk);
            #1;
            if (v_in) begin
                nv++;
                if (nv == 4) begin
                    check("t1_done_pre", 64'(dprev), 64'd0);
                    check("t1_done_rise", 64'(done), 64'd1);
                end
            end
            dprev = done;
        end
        check("t1_nv", 64'(nv), 64'd4);
        check("t1_error", 64'(error), 64'd0);
        check("t1_mcount", 64'(mcount), 64'd0);

        // T2: ready held low keeps the offered entry stable
        do_reset();
        load_basic();
        resp_en = 1'b1;
        f0 = fire_cnt;
        pulse_start();
        p0 = pkt;
        t0 = ptag;
        check("t2_pkt", 64'(p0), 64'h1000);
        check("t2_ptag", 64'(t0), 64'h100);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (pkt !== p0 || ptag !== t0 || trace_addr !== 5'd0
                || pkt_v !== 1'b1) begin
                stable = 1'b0;
            end
        end
        check("t2_stable", 64'(stable), 64'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_one_fire", 64'(fire_cnt - f0), 64'd1);
        check("t2_addr", 64'(trace_addr), 64'd1);

        // T3: stalled responder fills the in-flight window
        do_reset();
        clear_rom();
        for (int i = 0; i < 20; i++) begin
            rom[i] = mk(1'b0, 1'b1, 64'h0, TW'(i), PW'(16'h2000 + i));
        end
        man_data = 64'h0;
        ready    = 1'b1;
        f0 = fire_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        check("t3_fires", 64'(fire_cnt - f0), 64'd8);
        check("t3_v_low", 64'(pkt_v), 64'd0);
        check("t3_addr", 64'(trace_addr), 64'd8);
        man_v = 1'b1;
        @(negedge clk);
        man_v = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_fires2", 64'(fire_cnt - f0), 64'd9);
        check("t3_v_low2", 64'(pkt_v), 64'd0);
        check("t3_addr2", 64'(trace_addr), 64'd9);
        check("t3_mcount", 64'(mcount), 64'd0);

        // T4: entry 5 returns wrong data
        do_reset();
        clear_rom();
        for (int i = 0; i < 8; i++) begin
            rom[i] = mk(1'b0, 1'b1, 64'h1111_0000 + 64'(i), TW'(i), PW'(i));
            resp_mem[i] = 64'h1111_0000 + 64'(i);
        end
        rom[5]      = mk(1'b0, 1'b1, 64'hDEAD_BEEF, 12'h5, 16'h5);
        resp_mem[5] = 64'h0;
        ready   = 1'b1;
        resp_en = 1'b1;
        pulse_start();
        wait_done(100, "t4_done");
        check("t4_mcount", 64'(mcount), 64'd1);
        check("t4_ferr", 64'(ferr), 64'd5);
        check("t4_error", 64'(error), 64'd1);
        check("t4_timeout", 64'(timeout), 64'd0);

        // T5: no results ever return
        do_reset();
        clear_rom();
        for (int i = 0; i < 3; i++) begin
            rom[i] = mk(1'b0, 1'b1, 64'h0, TW'(i), PW'(i));
        end
        ready = 1'b1;
        pulse_start();
        repeat (TO) @(posedge clk);
        #1;
        check("t5_to_early", 64'(timeout), 64'd0);
        check("t5_done_early", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("t5_timeout", 64'(timeout), 64'd1);
        check("t5_done", 64'(done), 64'd1);
        check("t5_error", 64'(error), 64'd1);

        // T6: result before start
        do_reset();
        clear_rom();
        @(negedge clk);
        man_v = 1'b1;
        @(negedge clk);
        man_v = 1'b0;
        check("t6_unexp", 64'(unexpected), 64'd1);
        check("t6_error", 64'(error), 64'd1);
        check("t6_mcount", 64'(mcount), 64'd0);

        // T7: reset mid-replay, then clean restart
        do_reset();
        load_basic();
        ready   = 1'b1;
        resp_en = 1'b1;
        pulse_start();
        k = 0;
        while (trace_addr != 5'd2 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t7_reach2", 64'(trace_addr), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t7_addr", 64'(trace_addr), 64'd0);
        check("t7_pkt_v", 64'(pkt_v), 64'd0);
        check("t7_done", 64'(done), 64'd0);
        check("t7_error", 64'(error), 64'd0);
        check("t7_timeout", 64'(timeout), 64'd0);
        check("t7_unexp", 64'(unexpected), 64'd0);
        check("t7_mcount", 64'(mcount), 64'd0);
        check("t7_ferr", 64'(ferr), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        check("t7_restart_addr", 64'(trace_addr), 64'd0);
        check("t7_restart_v", 64'(pkt_v), 64'd1);
        wait_done(100, "t7_done2");
        check("t7_error2", 64'(error), 64'd0);
        check("t7_unexp2", 64'(unexpected), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

endmodule
